// File: rtl/elem_ram_host_pkg.sv
// Shared constants, beat-count helper and host FSM encoding for the element RAM host port.
package elem_ram_host_pkg;

  localparam int unsigned ElemWDef = 198;
  localparam int unsigned BusWDef  = 32;
  localparam int unsigned AddrWDef = 7;

  function automatic int unsigned calc_beats(input int unsigned elem_w,
                                             input int unsigned bus_w);
    return (elem_w + bus_w - 1) / bus_w;
  endfunction

  typedef enum logic [2:0] {
    StIdle,
    StWLoad,
    StWCommit,
    StRRead,
    StRStream
  } host_st_e;

endpackage

// File: rtl/elem_ram.sv
// Single-port synchronous element RAM with registered, read-first output and no reset.
module elem_ram
  import elem_ram_host_pkg::*;
#(
  parameter int unsigned ElemW = ElemWDef,
  parameter int unsigned AddrW = AddrWDef
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [ElemW-1:0] wdata_i,
  output logic [ElemW-1:0] rdata_o
);

  logic [ElemW-1:0] mem_q [2**AddrW];
  logic [ElemW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/elem_ram_host.sv
// Field-element RAM: narrow beat-streaming host port sharing a single-port RAM with a
// full-width core port that owns the RAM whenever the host FSM is idle.
module elem_ram_host
  import elem_ram_host_pkg::*;
#(
  parameter int unsigned ElemW = ElemWDef,
  parameter int unsigned BusW  = BusWDef,
  parameter int unsigned AddrW = AddrWDef
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             h_sel_i,
  input  logic             h_w_i,
  input  logic [AddrW-1:0] h_addr_i,
  input  logic             h_valid_i,
  input  logic [BusW-1:0]  h_wdata_i,
  output logic             h_ready_o,
  output logic [BusW-1:0]  h_rdata_o,
  output logic             h_rvalid_o,
  output logic             h_last_o,
  output logic             h_busy_o,
  input  logic             c_busy_i,
  input  logic [AddrW-1:0] c_addr_i,
  input  logic             c_we_i,
  input  logic [ElemW-1:0] c_wdata_i,
  output logic [ElemW-1:0] c_rdata_o
);

  localparam int unsigned Beats = calc_beats(ElemW, BusW);
  localparam int unsigned BufW  = Beats * BusW;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

  host_st_e         state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [BufW-1:0]  asm_q, asm_d;
  logic [BufW-1:0]  rd_q, rd_d;
  logic [BufW-1:0]  asm_shift;
  logic             h_ready;

  logic             core_sel_q;
  logic [ElemW-1:0] c_hold_q;

  logic             ram_we;
  logic [AddrW-1:0] ram_addr;
  logic [ElemW-1:0] ram_wdata;
  logic [ElemW-1:0] ram_rdata;

  // Beats enter at the top and walk down, so beat 0 ends up in the least-significant slot.
  assign asm_shift = {h_wdata_i, asm_q[BufW-1:BusW]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    asm_d   = asm_q;
    rd_d    = rd_q;
    h_ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        h_ready = !c_busy_i;
        if (h_valid_i && h_ready && h_sel_i) begin
          addr_d = h_addr_i;
          if (h_w_i) begin
            asm_d   = asm_shift;
            cnt_d   = CntW'(1);
            state_d = StWLoad;
          end else begin
            cnt_d   = '0;
            state_d = StRRead;
          end
        end
      end

      StWLoad: begin
        h_ready = 1'b1;
        if (!h_sel_i) begin
          state_d = StIdle;
        end else if (h_valid_i) begin
          asm_d = asm_shift;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = StWCommit;
          end
        end
      end

      StWCommit: begin
        state_d = StIdle;
      end

      // First cycle launches the RAM read, second captures its registered output.
      StRRead: begin
        if (cnt_q == '0) begin
          cnt_d = CntW'(1);
        end else begin
          rd_d    = BufW'(ram_rdata);
          cnt_d   = '0;
          state_d = StRStream;
        end
      end

      StRStream: begin
        rd_d  = {{BusW{1'b0}}, rd_q[BufW-1:BusW]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      asm_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      asm_q   <= asm_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    if (state_q == StIdle) begin
      ram_addr  = c_addr_i;
      ram_we    = c_we_i;
      ram_wdata = c_wdata_i;
    end else begin
      ram_addr  = addr_q;
      ram_we    = (state_q == StWCommit);
      ram_wdata = asm_q[ElemW-1:0];
    end
  end

  elem_ram #(
    .ElemW(ElemW),
    .AddrW(AddrW)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  // The RAM output is reused by host reads, so the core sees a held copy while the host owns it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      core_sel_q <= 1'b0;
      c_hold_q   <= '0;
    end else begin
      core_sel_q <= (state_q == StIdle);
      if (core_sel_q) begin
        c_hold_q <= ram_rdata;
      end
    end
  end

  assign c_rdata_o  = core_sel_q ? ram_rdata : c_hold_q;
  assign h_ready_o  = h_ready;
  assign h_busy_o   = (state_q != StIdle);
  assign h_rvalid_o = (state_q == StRStream);
  assign h_last_o   = h_rvalid_o && (cnt_q == LastCnt);
  assign h_rdata_o  = h_rvalid_o ? rd_q[BusW-1:0] : '0;

endmodule

// File: tb/tb_elem_ram_host.sv
// Randomised scoreboard bench for elem_ram_host: host reads queue expected beats from an
// array model of the RAM and a negedge monitor pops and compares them as the DUT streams.
module tb_elem_ram_host;

  localparam logic [197:0] E0 = 198'h115a25886512165251569195908560596a6695612620504191;
  localparam logic [197:0] E1 = 198'h1559546442405a181195655549614540592955a15a26984015;
  localparam logic [197:0] E2 = 198'h12222222222222222222222222222222222222222222222222;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         h_sel, h_w, h_valid;
  logic [6:0]   h_addr;
  logic [31:0]  h_wdata;
  logic         h_ready, h_rvalid, h_last, h_busy;
  logic [31:0]  h_rdata;
  logic         c_busy;
  logic [6:0]   c_addr;
  logic         c_we, c_we_req, spam_mode;
  logic [197:0] c_wdata, c_rdata, hold_exp;

  int checks = 0;
  int errors = 0;

  beat_t        exp_q[$];
  logic [197:0] mem [128];
  bit           known [128];

  // In spam mode the core writes exactly when the host owns the RAM; all of those must drop.
  assign c_we = c_we_req & (!spam_mode | h_busy);

  elem_ram_host dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .h_sel_i   (h_sel),
    .h_w_i     (h_w),
    .h_addr_i  (h_addr),
    .h_valid_i (h_valid),
    .h_wdata_i (h_wdata),
    .h_ready_o (h_ready),
    .h_rdata_o (h_rdata),
    .h_rvalid_o(h_rvalid),
    .h_last_o  (h_last),
    .h_busy_o  (h_busy),
    .c_busy_i  (c_busy),
    .c_addr_i  (c_addr),
    .c_we_i    (c_we),
    .c_wdata_i (c_wdata),
    .c_rdata_o (c_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [197:0] rand_elem();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom;
    return t[197:0];
  endfunction

  task automatic push_read(input logic [197:0] data);
    logic [223:0] ext;
    beat_t b;
    ext = '0;
    ext[197:0] = data;
    for (int k = 0; k < 7; k++) begin
      b.last = (k == 6);
      b.data = ext[k*32 +: 32];
      exp_q.push_back(b);
    end
  endtask

  // Monitor: any read beat must match the head of the scoreboard queue.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n === 1'b1) begin
      if (h_rvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid: got beat %0h want none", h_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rd_beat", {h_last, h_rdata}, {e.last, e.data});
          if (e.last) chk("last_beat_pad", h_rdata[31:6], 0);
        end
      end else if (h_last) begin
        chk("last_without_rvalid", h_last, 0);
      end
      if (spam_mode && h_busy) chk("c_rdata_hold", c_rdata, hold_exp);
    end
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!h_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!h_ready) begin
      checks++;
      errors++;
      $display("FAIL %s: h_ready stayed 0, want 1 within 50 cycles", name);
    end
  endtask

  task automatic host_write(input logic [6:0] addr, input logic [197:0] data,
                            input bit gaps, input bit cb);
    logic [223:0] ext;
    ext = '0;
    ext[197:0] = data;
    for (int k = 0; k < 7; k++) begin
      if (gaps && k > 0) begin
        repeat ($urandom_range(0, 2)) begin
          h_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      if (cb && k == 3) c_busy = 1'b1;
      h_sel   = 1'b1;
      h_w     = (k == 0) ? 1'b1 : 1'($urandom);
      h_addr  = (k == 0) ? addr : 7'($urandom);
      h_valid = 1'b1;
      h_wdata = ext[k*32 +: 32];
      wait_ready("wr_beat");
      @(posedge clk);
      #1;
    end
    h_valid = 1'b0;
    h_sel   = 1'b0;
    @(negedge clk);
    chk("commit_ready_low", h_ready, 0);
    chk("commit_busy", h_busy, 1);
    @(posedge clk);
    #1;
    c_busy    = 1'b0;
    mem[addr]   = data;
    known[addr] = 1'b1;
  endtask

  task automatic read_tail(input logic [6:0] addr);
    int n;
    h_valid = 1'b0;
    h_sel   = 1'b0;
    h_addr  = 7'($urandom);
    push_read(mem[addr]);
    @(negedge clk);
    chk("rd_lat_t0", h_rvalid, 0);
    @(negedge clk);
    chk("rd_lat_t1", h_rvalid, 0);
    n = 0;
    while ((exp_q.size() != 0 || h_busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || h_busy) begin
      checks++;
      errors++;
      $display("FAIL rd_drain: got %0d beats pending busy=%0b, want 0 pending", exp_q.size(),
               h_busy);
      exp_q.delete();
    end
    chk("ready_after_last", h_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic host_read(input logic [6:0] addr);
    h_sel   = 1'b1;
    h_w     = 1'b0;
    h_addr  = addr;
    h_valid = 1'b1;
    wait_ready("rd_accept");
    @(posedge clk);
    #1;
    read_tail(addr);
  endtask

  task automatic core_read(input logic [6:0] addr);
    c_addr = addr;
    @(posedge clk);
    @(negedge clk);
    chk("core_read", c_rdata, mem[addr]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]   a;
    logic [197:0] d;
    rst_n = 1'b0;
    h_sel = 1'b0; h_w = 1'b0; h_valid = 1'b0; h_addr = '0; h_wdata = '0;
    c_busy = 1'b0; c_addr = '0; c_we_req = 1'b0; spam_mode = 1'b0; c_wdata = '0;
    hold_exp = '0;
    for (int i = 0; i < 128; i++) known[i] = 1'b0;

    #3;
    chk("rst_busy", h_busy, 0);
    chk("rst_rvalid", h_rvalid, 0);
    chk("rst_last", h_last, 0);
    chk("rst_rdata", h_rdata, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_ready", h_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed element round trip.
    host_write(7'd0, E0, 1'b0, 1'b0);
    host_write(7'd3, E1, 1'b0, 1'b0);
    host_read(7'd0);
    host_read(7'd3);

    // Without h_sel nothing is accepted, and h_valid=0 with h_sel does nothing.
    h_sel = 1'b0; h_valid = 1'b1; h_w = 1'b1; h_addr = 7'd3; h_wdata = $urandom;
    repeat (3) begin
      @(negedge clk);
      chk("nosel_busy", h_busy, 0);
    end
    @(posedge clk);
    #1;
    h_sel = 1'b1; h_valid = 1'b0; h_w = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("novalid_busy", h_busy, 0);
    end
    @(posedge clk);
    #1;
    h_sel = 1'b0;
    host_read(7'd3);

    // Core busy blocks a pending request until it drops.
    c_busy = 1'b1;
    h_sel = 1'b1; h_w = 1'b0; h_addr = 7'd0; h_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("cbusy_ready", h_ready, 0);
      chk("cbusy_blocked", h_busy, 0);
    end
    @(posedge clk);
    #1;
    c_busy = 1'b0;
    @(negedge clk);
    chk("cbusy_release_ready", h_ready, 1);
    @(posedge clk);
    #1;
    chk("cbusy_accepted", h_busy, 1);
    read_tail(7'd0);

    // Aborted write leaves the old element in place.
    for (int k = 0; k < 3; k++) begin
      h_sel = 1'b1; h_w = 1'b1; h_addr = 7'd3; h_valid = 1'b1; h_wdata = E2[k*32 +: 32];
      wait_ready("abort_beat");
      @(posedge clk);
      #1;
    end
    h_sel = 1'b0;
    @(negedge clk);
    chk("abort_busy_wload", h_busy, 1);
    @(posedge clk);
    #1;
    h_valid = 1'b0;
    @(negedge clk);
    chk("abort_idle", h_busy, 0);
    @(posedge clk);
    #1;
    host_read(7'd3);

    // Core write then read, including read-first on a same-address write.
    c_addr = 7'd5; c_wdata = 198'd1; c_we_req = 1'b1;
    @(posedge clk);
    #1;
    c_we_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("core_wr1", c_rdata, 1);
    @(posedge clk);
    #1;
    c_wdata = 198'd2; c_we_req = 1'b1;
    @(posedge clk);
    #1;
    c_we_req = 1'b0;
    @(negedge clk);
    chk("core_read_first", c_rdata, 1);
    @(posedge clk);
    @(negedge clk);
    chk("core_wr2", c_rdata, 2);
    @(posedge clk);
    #1;
    mem[5] = 198'd2;
    known[5] = 1'b1;

    // Core writes while the host owns the RAM are dropped; c_rdata holds.
    d = rand_elem();
    host_write(7'd6, d, 1'b1, 1'b0);
    c_addr = 7'd6; c_wdata = ~d; c_we_req = 1'b1; spam_mode = 1'b1; hold_exp = mem[6];
    @(posedge clk);
    #1;
    host_read(7'd6);
    host_write(7'd6, rand_elem(), 1'b0, 1'b0);
    spam_mode = 1'b0; c_we_req = 1'b0;
    hold_exp = mem[6];
    host_read(7'd6);
    core_read(7'd6);

    // Randomised traffic, with c_busy sometimes rising mid-write.
    for (int it = 0; it < 16; it++) begin
      a = 7'(8 + $urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: host_write(a, rand_elem(), 1'b1, 1'($urandom));
        1: if (known[a]) host_read(a); else host_write(a, rand_elem(), 1'b1, 1'b0);
        default: if (known[a]) core_read(a); else host_write(a, rand_elem(), 1'b0, 1'b1);
      endcase
    end

    // Reset in the middle of a read stream.
    h_sel = 1'b1; h_w = 1'b0; h_addr = 7'd0; h_valid = 1'b1;
    wait_ready("rst_rd_accept");
    @(posedge clk);
    #1;
    h_sel = 1'b0; h_valid = 1'b0;
    push_read(mem[0]);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", h_rvalid, 0);
    chk("midrst_last", h_last, 0);
    chk("midrst_rdata", h_rdata, 0);
    chk("midrst_busy", h_busy, 0);
    chk("midrst_c_rdata", c_rdata, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    host_read(7'd0);
    host_read(7'd3);
    core_read(7'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
